// File: rtl/tt_sweep_capture.sv
//-----------------------------------------------------------------------------
// tt_sweep_capture
//
// Purpose:
//   Test-harness stage for one 7-input function block. It drives all 128
//   input vectors onto x in ascending order. It captures the block's output
//   for each vector into a 128-bit truth table. It then compares that table
//   against a golden signature. Each vector is held for SETTLE+1 cycles, and
//   f_in is sampled on the last of those cycles.
//
// Optional build macro:
//   EARLY_ABORT_EN - when defined, the sweep stops at the first mismatching
//                    vector. DONE follows on the next cycle, mismatch_cnt is
//                    1 and the tt bits above the failing index stay 0.
//                    When undefined, a full 128-vector sweep always runs.
//
// Ports:
//   clk           in   single clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   one-cycle sweep request, accepted only in IDLE
//   expected[127] in   golden table, bit i = f(x=i), latched on acceptance
//   x[6:0]        out  vector driven to the function block (0 outside RUN)
//   f_in          in   function block output, combinational from x
//   busy          out  high while the sweep runs
//   done          out  one-cycle pulse at sweep end
//   match         out  captured table equals golden (valid from done)
//   tt[127:0]     out  captured truth table
//   mismatch_cnt  out  number of differing bits, 0..128
//   first_err_idx out  lowest mismatching vector index, 0 when none
//
// Handshake: start is a single-cycle request with no ready. It is taken on a
// rising edge only while the FSM is IDLE. At any other time it is dropped,
// with no queuing. Results stay stable from done until the next accepted
// start.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tt_sweep_capture #(
   parameter int unsigned SETTLE = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] expected,
   output logic [6:0]   x,
   input  logic         f_in,
   output logic         busy,
   output logic         done,
   output logic         match,
   output logic [127:0] tt,
   output logic [7:0]   mismatch_cnt,
   output logic [6:0]   first_err_idx
);

   // The vector count is fixed by the 7-bit input width.
   localparam int unsigned NVEC     = 128;
   localparam logic [6:0]  LAST_IDX = 7'(NVEC - 1);
   localparam logic [3:0]  SETTLE_L = 4'(SETTLE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state;
   state_t       state_nx;
   logic [127:0] exp_q;
   logic [6:0]   idx;
   logic [3:0]   hold;
   logic         accept;
   logic         sample;
   logic         miss;
   logic         last;
   logic [7:0]   cnt_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      sample   = 1'b0;
      miss     = 1'b0;
      last     = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      x        = '0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            x    = idx;
            if (hold == SETTLE_L) begin
               sample = 1'b1;
               miss   = (f_in != exp_q[idx]);
               last   = (idx == LAST_IDX);
`ifdef EARLY_ABORT_EN
               // The first mismatch ends the sweep, whatever the index.
               if (miss) begin
                  last = 1'b1;
               end
`endif
               if (last) begin
                  state_nx = DONE;
               end
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Count including the sample taken this cycle, so the final vector is
   // reflected in match on the same edge that enters DONE.
   assign cnt_nx = mismatch_cnt + {7'd0, miss};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q         <= '0;
         idx           <= '0;
         hold          <= '0;
         tt            <= '0;
         mismatch_cnt  <= '0;
         first_err_idx <= '0;
         match         <= 1'b0;
      end else if (accept) begin
         exp_q         <= expected;
         idx           <= '0;
         hold          <= '0;
         tt            <= '0;
         mismatch_cnt  <= '0;
         first_err_idx <= '0;
         match         <= 1'b0;
      end else if (state == RUN) begin
         if (sample) begin
            tt[idx]      <= f_in;
            mismatch_cnt <= cnt_nx;
            if (miss && (mismatch_cnt == 8'd0)) begin
               first_err_idx <= idx;
            end
            if (last) begin
               match <= (cnt_nx == 8'd0);
               idx   <= '0;
            end else begin
               idx <= idx + 7'd1;
            end
            hold <= '0;
         end else begin
            hold <= hold + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_tt_sweep_capture.sv
//-----------------------------------------------------------------------------
// tb_tt_sweep_capture
//
// Purpose:
//   Directed bench for tt_sweep_capture. There are two instances:
//   - u_dut0 uses SETTLE=0. Its f_in comes from a table-driven stand-in for
//     the function block.
//   - u_dut3 uses SETTLE=3. Its f_in comes from a second table, held at 0 for
//     the tied-low case.
//   When a sweep starts, the expected result is computed from a behavioural
//   model and pushed to a queue. It is popped and compared when done pulses.
//
// Ports: none (top-level bench).
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tt_sweep_capture;

   localparam logic [127:0] REF_TT = 128'hfeeefae8fce8f880fee0e8c0e8a08880;

   typedef struct packed {
      logic [127:0] tt;
      logic [7:0]   cnt;
      logic [6:0]   first;
      logic         match;
      logic [15:0]  lat;
   } res_t;

   // clock / reset
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DUT signals
   logic         start0, start3;
   logic [127:0] exp0, exp3;
   logic [127:0] fn0, fn3;
   logic [6:0]   x0, x3;
   logic         f_in0, f_in3;
   logic         busy0, busy3, done0, done3, match0, match3;
   logic [127:0] tt0, tt3;
   logic [7:0]   cnt0, cnt3;
   logic [6:0]   first0, first3;

   assign f_in0 = fn0[x0];
   assign f_in3 = fn3[x3];

   tt_sweep_capture #(.SETTLE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp0), .x(x0),
      .f_in(f_in0), .busy(busy0), .done(done0), .match(match0), .tt(tt0),
      .mismatch_cnt(cnt0), .first_err_idx(first0)
   );

   tt_sweep_capture #(.SETTLE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3), .x(x3),
      .f_in(f_in3), .busy(busy3), .done(done3), .match(match3), .tt(tt3),
      .mismatch_cnt(cnt3), .first_err_idx(first3)
   );

   // Selected instance under observation
   logic         sel;
   logic [6:0]   s_x;
   logic         s_busy, s_done, s_match;
   logic [127:0] s_tt;
   logic [7:0]   s_cnt;
   logic [6:0]   s_first;

   always_comb begin
      if (sel) begin
         s_x = x3; s_busy = busy3; s_done = done3; s_match = match3;
         s_tt = tt3; s_cnt = cnt3; s_first = first3;
      end else begin
         s_x = x0; s_busy = busy0; s_done = done0; s_match = match0;
         s_tt = tt0; s_cnt = cnt0; s_first = first0;
      end
   end

   // scoreboard
   res_t sb[$];
   int   total;
   int   passed;
   int   failed;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural reference: walk the vectors in order, stopping at the first
   // mismatch when the early-abort build is selected.
   function automatic res_t model(input logic [127:0] fn, input logic [127:0] ex, input int settle);
      res_t r;
      int   last_i;
      bit   found;
      r      = '0;
      last_i = 127;
      found  = 1'b0;
      for (int i = 0; i < 128; i++) begin
         r.tt[i] = fn[i];
         if (fn[i] !== ex[i]) begin
            r.cnt = r.cnt + 8'd1;
            if (!found) begin
               r.first = 7'(i);
               found   = 1'b1;
            end
`ifdef EARLY_ABORT_EN
            last_i = i;
            break;
`endif
         end
      end
      r.match = (r.cnt == 8'd0);
      r.lat   = 16'((last_i + 1) * (settle + 1) + 1);
      return r;
   endfunction

   // driver: request a sweep and return 1ns after the accepting edge
   task automatic start_sweep(input bit which, input logic [127:0] fn, input logic [127:0] ex, input int settle);
      @(negedge clk);
      sel = which;
      if (which) begin
         fn3 = fn; exp3 = ex; start3 = 1'b1;
      end else begin
         fn0 = fn; exp0 = ex; start0 = 1'b1;
      end
      sb.push_back(model(fn, ex, settle));
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start3 = 1'b0;
   endtask

   // monitor: follow the sweep until done, then compare against the queue
   task automatic wait_done(input int settle, input bit perturb, input int abort_at,
                            input bit restart, input logic [127:0] rex);
      int         n;
      bit         seen;
      int         x_bad;
      res_t       e;
      logic [6:0] want_x;
      n = 0; seen = 1'b0; x_bad = 0;
      while (!seen && n < 2000) begin
         @(negedge clk);
         if (abort_at >= 0 && int'(s_x) == abort_at) begin
            #2 rst_n = 1'b0;
            #1 chk("async_reset_outputs",
                   160'({s_x, s_busy, s_done, s_match, s_tt, s_cnt, s_first}), 160'd0);
            void'(sb.pop_back());
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (n < 128 * (settle + 1)) begin
            want_x = 7'(n / (settle + 1));
            if (s_x !== want_x) x_bad++;
         end
         if (s_done === 1'b1) begin
            seen = 1'b1;
         end else begin
            n++;
            if (perturb) start0 = (n == 10 || n == 50);
         end
      end
      start0 = 1'b0;
      if (!seen) begin
         chk("done_timeout", 160'd0, 160'd1);
         void'(sb.pop_front());
         return;
      end
      e = sb.pop_front();
      chk("latency", 160'(n + 1), 160'(e.lat));
      chk("tt", 160'(s_tt), 160'(e.tt));
      chk("mismatch_cnt", 160'(s_cnt), 160'(e.cnt));
      chk("first_err_idx", 160'(s_first), 160'(e.first));
      chk("match", 160'(s_match), 160'(e.match));
      chk("busy_x_at_done", 160'({s_busy, s_x}), 160'd0);
      chk("x_step_errors", 160'(x_bad), 160'd0);
      if (restart) begin
         // start during the DONE cycle, held into the following IDLE cycle
         start0 = 1'b1;
         exp0   = rex;
         sb.push_back(model(fn0, rex, settle));
         @(negedge clk);
         chk("start_in_done_ignored", 160'({s_busy, s_done, s_match, s_tt}),
             160'({1'b0, 1'b0, e.match, e.tt}));
         @(posedge clk);
         #1;
         start0 = 1'b0;
         chk("cleared_on_accept", 160'({s_busy, s_match, s_tt, s_cnt, s_first}),
             160'({1'b1, 1'b0, 128'd0, 8'd0, 7'd0}));
      end else begin
         @(negedge clk);
         chk("single_done", 160'({s_done, s_busy}), 160'd0);
         repeat (3) @(negedge clk);
         chk("results_held", 160'({s_match, s_tt, s_cnt, s_first}),
             160'({e.match, e.tt, e.cnt, e.first}));
      end
   endtask

   initial begin
      logic [127:0] flip5;
      logic [127:0] flip127;
      logic [127:0] rnd;
      int           k;
      total = 0; passed = 0; failed = 0;
      rst_n = 1'b0; start0 = 1'b0; start3 = 1'b0; sel = 1'b0;
      fn0 = REF_TT; fn3 = '0; exp0 = '0; exp3 = '0;
      flip5   = REF_TT ^ (128'd1 << 5);
      flip127 = REF_TT ^ (128'd1 << 127);

      // reset state of both instances
      #12;
      chk("reset_dut0", 160'({x0, busy0, done0, match0, tt0, cnt0, first0}), 160'd0);
      chk("reset_dut3", 160'({x3, busy3, done3, match3, tt3, cnt3, first3}), 160'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // reference network, exact golden table
      start_sweep(1'b0, REF_TT, REF_TT, 0);
      wait_done(0, 1'b0, -1, 1'b0, '0);

      // single flipped bit at index 5
      start_sweep(1'b0, REF_TT, flip5, 0);
      wait_done(0, 1'b0, -1, 1'b0, '0);

      // mismatch at the last vector only
      start_sweep(1'b0, REF_TT, flip127, 0);
      wait_done(0, 1'b0, -1, 1'b0, '0);

      // f_in tied low against all-ones, SETTLE=3 instance
      start_sweep(1'b1, 128'd0, {128{1'b1}}, 3);
      wait_done(3, 1'b0, -1, 1'b0, '0);

      // stray start pulses during a sweep
      start_sweep(1'b0, REF_TT, REF_TT, 0);
      wait_done(0, 1'b1, -1, 1'b0, '0);

      // asynchronous reset at vector 60, then a fresh sweep
      start_sweep(1'b0, REF_TT, REF_TT, 0);
      wait_done(0, 1'b0, 60, 1'b0, '0);
      start_sweep(1'b0, REF_TT, REF_TT, 0);
      wait_done(0, 1'b0, -1, 1'b0, '0);

      // start in the DONE cycle ignored, one cycle later accepted
      start_sweep(1'b0, REF_TT, flip5, 0);
      wait_done(0, 1'b0, -1, 1'b1, REF_TT);
      wait_done(0, 1'b0, -1, 1'b0, '0);

      // random single-bit flip and fully random golden table
      k = int'($urandom_range(0, 127));
      start_sweep(1'b0, REF_TT, REF_TT ^ (128'd1 << k), 0);
      wait_done(0, 1'b0, -1, 1'b0, '0);
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      start_sweep(1'b0, REF_TT, rnd, 0);
      wait_done(0, 1'b0, -1, 1'b0, '0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Test-harness stage wrapped around one 7-input majority-network function block.
- Upstream role: drives all 128 input vectors onto x[6:0] in ascending order.
- Downstream role: samples the block's single output for each vector, assembles the 128-bit truth table and compares it against an expected signature.
- Used to confirm in silicon or emulation that a synthesized network realises its classified function.

Parameters:
- SETTLE, 0: extra hold cycles per vector before sampling f_in (0..15). Each vector occupies SETTLE+1 cycles.
- NVEC, 128: vector count. Fixed at 2^7; not to be overridden.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; accepted only in IDLE.
- expected  input  128  golden truth table; bit i = f(x=i). Sampled into an internal register on start acceptance.
- x  output  7  vector to function block; x[0] maps to input x0, x[6] to x6.
- f_in  input  1  function block output (combinational from x).
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse at sweep end.
- match  output  1  1 if captured table equals expected; valid from done and held until next start acceptance.
- tt  output  128  captured truth table, held until next start acceptance.
- mismatch_cnt  output  8  number of differing bits, 0..128.
- first_err_idx  output  7  index of lowest mismatching vector; 0 when none.

Behaviour:
- Reset (async, any state): state=IDLE, x=0, busy=0, done=0, match=0, tt=0, mismatch_cnt=0, first_err_idx=0, internal idx=0, hold counter=0.
- IDLE:
  - start=1 → latch expected; clear tt, mismatch_cnt, first_err_idx and match.
  - Set idx=0, x=0, hold=0; go to RUN.
- RUN (busy=1):
  - x = idx throughout.
  - hold counts 0..SETTLE. On the cycle hold==SETTLE, sample f_in:
    - tt[idx] = f_in.
    - If f_in != exp[idx], increment mismatch_cnt.
    - On the first such mismatch, also set first_err_idx=idx.
  - Then, if idx==127, go to DONE; else idx+1, hold=0.
  - idx is 7-bit with no wrap; termination occurs at 127 explicitly.
- DONE:
  - Lasts one cycle: done=1, busy=0.
  - match = (mismatch_cnt==0) computed with the final sample included.
  - Then return to IDLE; x returns to 0.
- Latency: start accepted at edge T; done is high during cycle T + 128*(SETTLE+1) + 1. With SETTLE=0, done is high at T+129.
- start while RUN or DONE is ignored; no queuing.
- Reset mid-sweep aborts immediately. Partial tt is cleared to 0, so results are never retained.
- mismatch_cnt saturates naturally at 128 (8 bits suffice).
- Result outputs are stable and unchanged between done and the next accepted start.

Optional Feature:
- Macro EARLY_ABORT_EN.
- Defined:
  - On the first mismatch sample, the FSM goes directly to DONE the following cycle.
  - mismatch_cnt=1, first_err_idx=failing index, match=0.
  - tt bits above the failing index remain 0.
  - Total latency = (first_err_idx+1)*(SETTLE+1)+1.
- Undefined: full 128-vector sweep always. Counting behaves as specified above.

Test Plan:
- Reference network 7-input 3-level majority function, expected=128'hfeeefae8fce8f880fee0e8c0e8a08880, SETTLE=0 → done at cycle 129 after start; match=1; tt equals expected; mismatch_cnt=0.
- Same network, expected with bit 5 flipped → match=0, mismatch_cnt=1, first_err_idx=5. Without EARLY_ABORT_EN, tt is still the true function and done is at 129. With EARLY_ABORT_EN, done is at cycle 7 and tt[127:6]=0.
- f_in tied 0, expected=all ones, SETTLE=3 → mismatch_cnt=128, first_err_idx=0, done at cycle 513. x is observed stepping every 4 cycles 0..127.
- Pulse start again at cycles 10 and 50 during a sweep → ignored. Single done pulse; results identical to an unperturbed run.
- Assert rst_n=0 asynchronously mid-RUN at idx=60 → all outputs are 0 immediately without a clock. A new start after release performs a full fresh sweep with correct result.
- start asserted in the DONE cycle → ignored. A start one cycle later is accepted; match/tt are cleared at acceptance.
